// File: rtl/fetch_unit.sv
// Instruction fetch: PC register, combinational imem read and a
// two-entry in-order {pc, instr} buffer feeding decode.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        fetch_en,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_instr,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_pc,
   output logic [31:0] out_instr,
   output logic [1:0]  fifo_count,
   output logic        misalign_err
);

   logic [31:0] r_pc;
   logic [31:0] r_pc0;
   logic [31:0] r_ins0;
   logic [31:0] r_pc1;
   logic [31:0] r_ins1;
   logic [1:0]  r_count;
   logic        r_mis;

   logic        w_full;
   logic        w_fire;
   logic        w_pop;
   logic        w_valid;

   assign w_full  = (r_count == 2'd2);
   assign w_valid = (r_count != 2'd0);
   assign w_fire  = fetch_en && !redirect_valid && !w_full;
   assign w_pop   = w_valid && out_ready && !redirect_valid;

   assign imem_addr    = r_pc;
   assign fifo_count   = r_count;
   assign out_valid    = w_valid;
   assign misalign_err = r_mis;

   // Head slot is masked so an empty buffer presents zeros
   assign out_pc    = w_valid ? r_pc0  : 32'h0;
   assign out_instr = w_valid ? r_ins0 : 32'h0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc    <= RESET_PC;
         r_pc0   <= 32'h0;
         r_ins0  <= 32'h0;
         r_pc1   <= 32'h0;
         r_ins1  <= 32'h0;
         r_count <= 2'd0;
         r_mis   <= 1'b0;
      end else begin
         r_mis <= redirect_valid && (redirect_pc[1:0] != 2'b00);
         if (redirect_valid) begin
            r_pc    <= {redirect_pc[31:2], 2'b00};
            r_count <= 2'd0;
         end else begin
            if (w_fire) begin
               r_pc <= r_pc + 32'd4;
            end
            case ({w_fire, w_pop})
               2'b10: begin
                  if (r_count == 2'd0) begin
                     r_pc0  <= r_pc;
                     r_ins0 <= imem_instr;
                  end else begin
                     r_pc1  <= r_pc;
                     r_ins1 <= imem_instr;
                  end
                  r_count <= r_count + 2'd1;
               end
               2'b01: begin
                  r_pc0   <= r_pc1;
                  r_ins0  <= r_ins1;
                  r_count <= r_count - 2'd1;
               end
               2'b11: begin
                  // Only reachable with one entry: new word becomes head
                  r_pc0  <= r_pc;
                  r_ins0 <= imem_instr;
               end
               default: begin
                  r_count <= r_count;
               end
            endcase
         end
      end
   end

endmodule
